imm_encoder: RTL and testbench

Pipelined immediate encoder: the inverse of the core's immediate generator. It accepts a base instruction word, an immediate-format select (same 3-bit encoding the decode stage uses) and a 32-bit immediate. It range-checks the immediate, scatters its bits into the format's instruction fields and emits the patched instruction over a valid/ready stream. It sits in front of the debug/program loader that writes IMEM and keeps running counts of encoded and rejected instructions.

---
 rtl/imm_encoder.sv | 198 +++++++++++++++++++
 tb/tb_imm_encoder.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage pipelined immediate encoder.
// Stage 1 range-checks the immediate against the selected format.
// Stage 2 scatters the immediate into the instruction word, or passes the base
// through untouched on error. Delivered results are tallied in two saturating
// counters.
module imm_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_sel,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_base,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    input  logic        cnt_clr,
    output logic [15:0] enc_count,
    output logic [15:0] err_count
);

    // Format selects, same encoding as the decode stage.
    typedef enum logic [2:0] {
        FMT_I  = 3'b000,
        FMT_S  = 3'b001,
        FMT_SB = 3'b010,
        FMT_UJ = 3'b011,
        FMT_U  = 3'b100
    } fmt_e;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Stage 1 registers.
    logic        s1_valid_q, s1_valid_d;
    logic [2:0]  s1_sel_q,   s1_sel_d;
    logic [31:0] s1_imm_q,   s1_imm_d;
    logic [31:0] s1_base_q,  s1_base_d;
    logic        s1_err_q,   s1_err_d;

    // Stage 2 (output) registers.
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_inst_q,  out_inst_d;
    logic        out_err_q,   out_err_d;

    // Counters.
    logic [15:0] enc_count_q, enc_count_d;
    logic [15:0] err_count_q, err_count_d;

    logic        s2_ready;
    logic        in_fire;
    logic        out_fire;
    logic        range_err;
    logic [31:0] merged_inst;

    // Handshake terms; each stage opens when the stage after it can take a beat.
    always_comb begin
        s2_ready = !out_valid_q || out_ready;
        in_ready = !s1_valid_q || s2_ready;
        in_fire  = in_valid && in_ready;
        out_fire = out_valid_q && out_ready;
    end

    // Range check: the immediate must fit the format's signed field and alignment.
    always_comb begin
        range_err = 1'b1;
        case (in_sel)
            FMT_I, FMT_S: range_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
            FMT_SB:       range_err = in_imm[0] || !((&in_imm[31:12]) || !(|in_imm[31:12]));
            FMT_UJ:       range_err = in_imm[0] || !((&in_imm[31:20]) || !(|in_imm[31:20]));
            FMT_U:        range_err = |in_imm[11:0];
            default:      range_err = 1'b1;
        endcase
    end

    // Stage 1 next state: load on acceptance, drain when stage 2 takes the beat.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sel_d   = s1_sel_q;
        s1_imm_d   = s1_imm_q;
        s1_base_d  = s1_base_q;
        s1_err_d   = s1_err_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_fire) begin
            s1_sel_d  = in_sel;
            s1_imm_d  = in_imm;
            s1_base_d = in_base;
            s1_err_d  = range_err;
        end
    end

    // Merge: overwrite only the immediate fields of the base word.
    always_comb begin
        merged_inst = s1_base_q;
        if (!s1_err_q) begin
            case (s1_sel_q)
                FMT_I: begin
                    merged_inst[31:20] = s1_imm_q[11:0];
                end
                FMT_S: begin
                    merged_inst[31:25] = s1_imm_q[11:5];
                    merged_inst[11:7]  = s1_imm_q[4:0];
                end
                FMT_SB: begin
                    merged_inst[31]    = s1_imm_q[12];
                    merged_inst[30:25] = s1_imm_q[10:5];
                    merged_inst[11:8]  = s1_imm_q[4:1];
                    merged_inst[7]     = s1_imm_q[11];
                end
                FMT_UJ: begin
                    merged_inst[31]    = s1_imm_q[20];
                    merged_inst[30:21] = s1_imm_q[10:1];
                    merged_inst[20]    = s1_imm_q[11];
                    merged_inst[19:12] = s1_imm_q[19:12];
                end
                FMT_U: begin
                    merged_inst[31:12] = s1_imm_q[31:12];
                end
                default: begin
                    merged_inst = s1_base_q;
                end
            endcase
        end
    end

    // Stage 2 next state: hold the result while the consumer stalls.
    always_comb begin
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_err_d   = out_err_q;
        if (s2_ready) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_inst_d = merged_inst;
                out_err_d  = s1_err_q;
            end
        end
    end

    // Counter next state: clear wins over a coincident delivery; both saturate.
    always_comb begin
        enc_count_d = enc_count_q;
        err_count_d = err_count_q;
        if (cnt_clr) begin
            enc_count_d = 16'h0000;
            err_count_d = 16'h0000;
        end else if (out_fire) begin
            if (out_err_q) begin
                if (err_count_q != CNT_MAX) begin
                    err_count_d = err_count_q + 16'd1;
                end
            end else begin
                if (enc_count_q != CNT_MAX) begin
                    enc_count_d = enc_count_q + 16'd1;
                end
            end
        end
    end

    // All state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sel_q    <= 3'b000;
            s1_imm_q    <= 32'h0;
            s1_base_q   <= 32'h0;
            s1_err_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_inst_q  <= 32'h0;
            out_err_q   <= 1'b0;
            enc_count_q <= 16'h0;
            err_count_q <= 16'h0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sel_q    <= s1_sel_d;
            s1_imm_q    <= s1_imm_d;
            s1_base_q   <= s1_base_d;
            s1_err_q    <= s1_err_d;
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_err_q   <= out_err_d;
            enc_count_q <= enc_count_d;
            err_count_q <= err_count_d;
        end
    end

    // Registered outputs.
    always_comb begin
        out_valid = out_valid_q;
        out_inst  = out_inst_q;
        out_err   = out_err_q;
        enc_count = enc_count_q;
        err_count = err_count_q;
    end

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed and randomized bench for imm_encoder with a
// range/field reference model and an in-order scoreboard.
module tb_imm_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_sel;
    logic [31:0] in_imm;
    logic [31:0] in_base;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic        cnt_clr;
    logic [15:0] enc_count;
    logic [15:0] err_count;

    int checkCount = 0;
    int errorCount = 0;
    int popCount   = 0;
    int modelEnc   = 0;
    int modelErr   = 0;

    logic [32:0] sbQueue[$];
    logic        prevStall = 1'b0;
    logic [31:0] prevInst  = 32'h0;
    logic        prevErr   = 1'b0;

    imm_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_imm    (in_imm),
        .in_base   (in_base),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .cnt_clr   (cnt_clr),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] setField(input logic [31:0] word, input int hi, input int lo,
                                             input logic [31:0] val);
        logic [31:0] w;
        w = word;
        for (int i = lo; i <= hi; i++) begin
            w[i] = val[i - lo];
        end
        return w;
    endfunction

    // Reference: representable ranges as signed intervals, then field placement.
    function automatic logic [32:0] refEncode(input logic [2:0] sel, input logic [31:0] imm,
                                              input logic [31:0] base);
        int          v;
        bit          ok;
        logic [31:0] inst;
        v    = imm;
        ok   = 1'b0;
        inst = base;
        case (sel)
            3'd0: begin
                ok = (v >= -2048) && (v <= 2047);
                inst = setField(inst, 31, 20, imm);
            end
            3'd1: begin
                ok = (v >= -2048) && (v <= 2047);
                inst = setField(inst, 31, 25, imm >> 5);
                inst = setField(inst, 11, 7, imm);
            end
            3'd2: begin
                ok = (v % 2 == 0) && (v >= -4096) && (v <= 4094);
                inst = setField(inst, 31, 31, imm >> 12);
                inst = setField(inst, 30, 25, imm >> 5);
                inst = setField(inst, 11, 8, imm >> 1);
                inst = setField(inst, 7, 7, imm >> 11);
            end
            3'd3: begin
                ok = (v % 2 == 0) && (v >= -1048576) && (v <= 1048574);
                inst = setField(inst, 31, 31, imm >> 20);
                inst = setField(inst, 30, 21, imm >> 1);
                inst = setField(inst, 20, 20, imm >> 11);
                inst = setField(inst, 19, 12, imm >> 12);
            end
            3'd4: begin
                ok = (v % 4096 == 0);
                inst = setField(inst, 31, 12, imm >> 12);
            end
            default: ok = 1'b0;
        endcase
        if (!ok) inst = base;
        return {!ok, inst};
    endfunction

    // Scoreboard and counter model, sampled on the falling edge.
    always @(negedge clk) begin
        logic [32:0] exp;
        logic        expErr;
        if (!rst_n) begin
            sbQueue.delete();
            modelEnc  = 0;
            modelErr  = 0;
            prevStall = 1'b0;
        end else begin
            checkOutput("enc_count", {16'h0, enc_count}, modelEnc);
            checkOutput("err_count", {16'h0, err_count}, modelErr);
            if (prevStall) begin
                checkOutput("stall_valid", {31'h0, out_valid}, 32'd1);
                checkOutput("stall_inst", out_inst, prevInst);
                checkOutput("stall_err", {31'h0, out_err}, {31'h0, prevErr});
            end
            if (out_valid && out_ready) begin
                popCount++;
                expErr = out_err;
                if (sbQueue.size() == 0) begin
                    checkOutput("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    exp = sbQueue.pop_front();
                    expErr = exp[32];
                    checkOutput("out_inst", out_inst, exp[31:0]);
                    checkOutput("out_err", {31'h0, out_err}, {31'h0, exp[32]});
                end
                if (expErr) modelErr = (modelErr < 65535) ? modelErr + 1 : 65535;
                else        modelEnc = (modelEnc < 65535) ? modelEnc + 1 : 65535;
            end
            if (cnt_clr) begin
                modelEnc = 0;
                modelErr = 0;
            end
            if (in_valid && in_ready) begin
                sbQueue.push_back(refEncode(in_sel, in_imm, in_base));
            end
            prevStall = out_valid && !out_ready;
            prevInst  = out_inst;
            prevErr   = out_err;
        end
    end

    // One-cycle synchronous reset pulse; leaves the bench just after a rising edge.
    task automatic pulseReset();
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        rst_n    = 1'b1;
    endtask

    // Offers one beat and holds it until accepted, bounded by a cycle budget.
    task automatic applyStimulus(input logic [2:0] sel, input logic [31:0] imm, input logic [31:0] base);
        bit accepted;
        accepted = 1'b0;
        in_sel   = sel;
        in_imm   = imm;
        in_base  = base;
        in_valid = 1'b1;
        for (int c = 0; c < 50 && !accepted; c++) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    // Single beat on an empty pipe with out_ready high; checks latency and result.
    task automatic runDirected(input string tag, input logic [2:0] sel, input logic [31:0] imm,
                               input logic [31:0] base, input logic [31:0] expInst, input logic expErr);
        out_ready = 1'b1;
        in_sel    = sel;
        in_imm    = imm;
        in_base   = base;
        in_valid  = 1'b1;
        @(negedge clk);
        checkOutput({tag, "_in_ready"}, {31'h0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput({tag, "_lat1"}, {31'h0, out_valid}, 32'd0);
        @(posedge clk); #1;
        checkOutput({tag, "_lat2"}, {31'h0, out_valid}, 32'd1);
        checkOutput({tag, "_inst"}, out_inst, expInst);
        checkOutput({tag, "_err"}, {31'h0, out_err}, {31'h0, expErr});
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pickImm();
        logic [31:0] edges[11];
        int          r;
        edges = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4096,
                  -32'sd4096, 32'd1048574, 32'd1048576, -32'sd1048576, 32'h12345000};
        r = $urandom_range(0, 3);
        case (r)
            0:       return $urandom;
            1:       return $urandom_range(0, 8191) - 32'd4096;
            2:       return edges[$urandom_range(0, 10)];
            default: return $urandom & 32'hFFFFF000;
        endcase
    endfunction

    initial begin
        int          accepts;
        int          idx;
        int          popStart;
        bit          pending;
        logic [2:0]  bpSel[3];
        logic [31:0] bpImm[3];
        logic [31:0] bpBase[3];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 3'd0;
        in_imm    = 32'h0;
        in_base   = 32'h0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state.
        checkOutput("rst_out_valid", {31'h0, out_valid}, 32'd0);
        checkOutput("rst_out_inst", out_inst, 32'h0);
        checkOutput("rst_out_err", {31'h0, out_err}, 32'd0);
        checkOutput("rst_enc", {16'h0, enc_count}, 32'd0);
        checkOutput("rst_err", {16'h0, err_count}, 32'd0);
        checkOutput("rst_in_ready", {31'h0, in_ready}, 32'd1);

        // Directed encodes.
        runDirected("i_type", 3'd0, 32'hFFFFFFFF, 32'h00008093, 32'hFFF08093, 1'b0);
        checkOutput("enc_after_i", {16'h0, enc_count}, 32'd1);
        runDirected("sb_type", 3'd2, 32'hFFFFFFFC, 32'h00208063, 32'hFE208EE3, 1'b0);
        runDirected("uj_type", 3'd3, 32'd8, 32'h000000EF, 32'h008000EF, 1'b0);
        runDirected("u_type", 3'd4, 32'h12345000, 32'h00000037, 32'h12345037, 1'b0);
        runDirected("s_type", 3'd1, 32'd8, 32'h00112023, 32'h00112423, 1'b0);

        // Directed errors: base passes through unchanged.
        runDirected("err_i", 3'd0, 32'd2048, 32'h00008093, 32'h00008093, 1'b1);
        runDirected("err_sb", 3'd2, 32'd3, 32'h00208063, 32'h00208063, 1'b1);
        runDirected("err_u", 3'd4, 32'h12345001, 32'h00000037, 32'h00000037, 1'b1);
        runDirected("err_sel", 3'd7, 32'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
        checkOutput("err_total", {16'h0, err_count}, 32'd4);
        checkOutput("enc_unchanged", {16'h0, enc_count}, 32'd5);

        // Backpressure: three beats offered, only two fit while stalled.
        bpSel  = '{3'd0, 3'd1, 3'd4};
        bpImm  = '{32'd5, 32'd17, 32'hABCDE000};
        bpBase = '{32'h00000013, 32'h00002023, 32'h00000037};
        out_ready = 1'b0;
        accepts   = 0;
        idx       = 0;
        popStart  = popCount;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_sel   = bpSel[idx];
            in_imm   = bpImm[idx];
            in_base  = bpBase[idx];
            @(negedge clk);
            if (in_ready) begin
                accepts++;
                idx++;
            end
            @(posedge clk); #1;
        end
        checkOutput("bp_accepts", accepts, 32'd2);
        checkOutput("bp_in_ready", {31'h0, in_ready}, 32'd0);
        checkOutput("bp_out_valid", {31'h0, out_valid}, 32'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 10 && idx < 3; c++) begin
            in_sel  = bpSel[idx];
            in_imm  = bpImm[idx];
            in_base = bpBase[idx];
            @(negedge clk);
            if (in_ready) idx++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("bp_delivered", popCount - popStart, 32'd3);
        checkOutput("bp_queue_empty", sbQueue.size(), 32'd0);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        applyStimulus(3'd0, 32'd1, 32'h00000013);
        applyStimulus(3'd0, 32'd2, 32'h00000013);
        pulseReset();
        checkOutput("mid_rst_valid", {31'h0, out_valid}, 32'd0);
        checkOutput("mid_rst_enc", {16'h0, enc_count}, 32'd0);
        checkOutput("mid_rst_err", {16'h0, err_count}, 32'd0);
        runDirected("post_rst", 3'd0, 32'hFFFFFFFF, 32'h00008093, 32'hFFF08093, 1'b0);

        // Randomized traffic with random backpressure.
        pending = 1'b0;
        for (int c = 0; c < 600; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!pending) begin
                int r;
                r = $urandom_range(0, 9);
                in_sel   = (r < 9) ? 3'(r % 5) : 3'($urandom_range(5, 7));
                in_imm   = pickImm();
                in_base  = $urandom;
                in_valid = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            pending = in_valid && !in_ready;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("rand_drained", sbQueue.size(), 32'd0);

        // Saturation: stream more than 65535 encodes.
        pulseReset();
        out_ready = 1'b1;
        in_sel    = 3'd0;
        in_imm    = 32'd1;
        in_base   = 32'h00000013;
        in_valid  = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("enc_saturated", {16'h0, enc_count}, 32'h0000FFFF);

        // Clear coincident with an error delivery.
        in_sel   = 3'd2;
        in_imm   = 32'd3;
        in_base  = 32'h00208063;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("clr_out_valid", {31'h0, out_valid}, 32'd1);
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        checkOutput("clr_enc", {16'h0, enc_count}, 32'd0);
        checkOutput("clr_err", {16'h0, err_count}, 32'd0);
        repeat (2) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
